imem_arbiter: RTL and testbench

Controller that sequences and shares the single-ported 128×32 instruction memory between two requesters: the processor fetch port and a program loader, which writes through the same port. After reset it holds the processor in a boot phase until the loader signals completion. In run mode it arbitrates each cycle with loader priority and a starvation bound for fetch. It sits between the PC/fetch stage, the loader, and the instruction memory array, and drives the array's address, write-data and write-enable.

---
 rtl/imem_arbiter.sv | 134 +++++++++++++
 tb/tb_imem_arbiter.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_arbiter.sv
// imem_arbiter: shares the single-ported instruction memory between the processor
// fetch port and the program loader.
//
// After reset the block sits in BOOT, where only the loader may access the memory.
// A load_done pulse moves it to RUN. In RUN each cycle is arbitrated with loader
// priority. A waiting fetch is granted once MAX_BURST loader grants have gone by.
//
// Ports:
//   clk, reset           single clock; reset is asynchronous and active-high
//   fetch_req/addr       fetch request and byte address; held until granted
//   fetch_gnt            fetch granted this cycle (combinational)
//   fetch_valid/instr/err  registered response, one cycle after the grant
//   load_req/addr/data   loader write request, word index and data
//   load_gnt             write performed at the end of this cycle (combinational)
//   load_done            single-cycle pulse marking the end of the boot image
//   booted               high in RUN
//   mem_addr/wdata/we    memory array drive
//   mem_rdata            combinational memory read data
module imem_arbiter #(
  parameter int unsigned ADDR_W    = 7,
  parameter int unsigned MAX_BURST = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [31:0]       fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [31:0]       fetch_instr,
  output logic              fetch_err,
  input  logic              load_req,
  input  logic [ADDR_W-1:0] load_addr,
  input  logic [31:0]       load_data,
  output logic              load_gnt,
  input  logic              load_done,
  output logic              booted,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic              mem_we,
  input  logic [31:0]       mem_rdata
);

  localparam int unsigned CntW = (MAX_BURST < 1) ? 1 : $clog2(MAX_BURST + 1);
  localparam logic [CntW-1:0] MaxBurstC = CntW'(MAX_BURST);

  typedef enum logic [0:0] {StBoot, StRun} state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] burst_cnt_q, burst_cnt_d;
  logic            fetch_valid_q, fetch_valid_d;
  logic            fetch_err_q, fetch_err_d;
  logic [31:0]     fetch_instr_q, fetch_instr_d;
  logic            addr_err;

  // Misaligned, or outside the 2^ADDR_W-word array.
  assign addr_err = (fetch_addr[1:0] != 2'b00) | (|fetch_addr[31:ADDR_W+2]);

  // State and arbitration.
  always_comb begin
    state_d     = state_q;
    burst_cnt_d = burst_cnt_q;
    fetch_gnt   = 1'b0;
    load_gnt    = 1'b0;
    case (state_q)
      StBoot: begin
        load_gnt    = load_req;
        burst_cnt_d = '0;
        // A write granted alongside load_done still completes this cycle.
        if (load_done) state_d = StRun;
      end
      StRun: begin
        if (fetch_req && load_req) begin
          // burst_cnt_q counts loader grants taken while fetch has been waiting.
          if (burst_cnt_q < MaxBurstC) begin
            load_gnt    = 1'b1;
            burst_cnt_d = burst_cnt_q + 1'b1;
          end else begin
            fetch_gnt   = 1'b1;
            burst_cnt_d = '0;
          end
        end else begin
          fetch_gnt   = fetch_req;
          load_gnt    = load_req;
          burst_cnt_d = '0;
        end
      end
      default: state_d = StBoot;
    endcase
  end

  // Memory drive; only one of the grants can be active.
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_we    = 1'b0;
    if (load_gnt) begin
      mem_addr  = load_addr;
      mem_wdata = load_data;
      mem_we    = 1'b1;
    end else if (fetch_gnt) begin
      mem_addr = fetch_addr[ADDR_W+1:2];
    end
  end

  // Fetch response. An error fetch still takes its slot and returns zero data.
  always_comb begin
    fetch_valid_d = fetch_gnt;
    fetch_err_d   = fetch_gnt & addr_err;
    fetch_instr_d = fetch_instr_q;
    if (fetch_gnt) fetch_instr_d = addr_err ? 32'h0 : mem_rdata;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= StBoot;
      burst_cnt_q   <= '0;
      fetch_valid_q <= 1'b0;
      fetch_err_q   <= 1'b0;
      fetch_instr_q <= 32'h0;
    end else begin
      state_q       <= state_d;
      burst_cnt_q   <= burst_cnt_d;
      fetch_valid_q <= fetch_valid_d;
      fetch_err_q   <= fetch_err_d;
      fetch_instr_q <= fetch_instr_d;
    end
  end

  assign booted      = (state_q == StRun);
  assign fetch_valid = fetch_valid_q;
  assign fetch_err   = fetch_err_q;
  assign fetch_instr = fetch_instr_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: directed boot/starvation/read-after-write/
// error/idle/reset sequences, a vector table, and randomized traffic checked
// against a behavioural model of the arbitration rules.
module tb_imem_arbiter;

  localparam int unsigned AW    = 7;
  localparam int unsigned MB    = 4;
  localparam int unsigned Depth = 1 << AW;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          fetch_req = 1'b0;
  logic [31:0]   fetch_addr = 32'h0;
  logic          fetch_gnt, fetch_valid, fetch_err;
  logic [31:0]   fetch_instr;
  logic          load_req = 1'b0;
  logic [AW-1:0] load_addr = '0;
  logic [31:0]   load_data = 32'h0;
  logic          load_gnt;
  logic          load_done = 1'b0;
  logic          booted;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          mem_we;
  logic [31:0]   mem_rdata;

  always #5 clk = ~clk;

  imem_arbiter #(.ADDR_W(AW), .MAX_BURST(MB)) dut (
    .clk        (clk),
    .reset      (reset),
    .fetch_req  (fetch_req),
    .fetch_addr (fetch_addr),
    .fetch_gnt  (fetch_gnt),
    .fetch_valid(fetch_valid),
    .fetch_instr(fetch_instr),
    .fetch_err  (fetch_err),
    .load_req   (load_req),
    .load_addr  (load_addr),
    .load_data  (load_data),
    .load_gnt   (load_gnt),
    .load_done  (load_done),
    .booted     (booted),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_we     (mem_we),
    .mem_rdata  (mem_rdata)
  );

  // Instruction memory array: combinational read, write at the clock edge.
  logic [31:0] mem [Depth];
  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] rand_faddr();
    logic [31:0] a;
    int unsigned k;
    k = $urandom_range(0, 9);
    a = 32'($urandom_range(0, Depth - 1)) << 2;
    if (k == 0) a[1:0] = 2'($urandom_range(1, 3));
    else if (k == 1) a = a | (32'h1 << $urandom_range(AW + 2, 31));
    return a;
  endfunction

  typedef struct packed {
    logic          freq;
    logic [31:0]   faddr;
    logic          lreq;
    logic [AW-1:0] laddr;
    logic [31:0]   ldata;
    logic          fgnt;
    logic          lgnt;
    logic          we;
    logic [AW-1:0] maddr;
    logic [31:0]   wdata;
  } vec_t;

  vec_t vecs [9];

  // Behavioural model state for the random phase.
  logic [31:0] m_mem [Depth];
  int          m_wait;      // loader grants in a row while fetch has been waiting
  logic        m_fg, m_lg, m_pv, m_perr, m_err;
  logic [31:0] m_last;
  logic [AW-1:0] m_maddr;
  logic [0:11] f_pat;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < int'(Depth); i++) mem[i] = 32'h0;

    // Reset values.
    @(posedge clk);
    #1;
    settle();
    chk("rst_booted", 32'(booted), 32'd0);
    chk("rst_valid", 32'(fetch_valid), 32'd0);
    chk("rst_err", 32'(fetch_err), 32'd0);
    chk("rst_instr", fetch_instr, 32'h0);
    next_cycle();
    reset = 1'b0;

    // Boot gating.
    for (int c = 0; c < 10; c++) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'h0;
      load_req   = (c < 4);
      load_addr  = AW'(c);
      load_data  = 32'h1000_0000 + 32'(c);
      load_done  = (c == 5);
      settle();
      if (c <= 5) begin
        chk("boot_fgnt", 32'(fetch_gnt), 32'd0);
        chk("boot_booted", 32'(booted), 32'd0);
      end
      if (c < 4) chk("boot_lgnt", 32'(load_gnt), 32'd1);
      if (c == 6) begin
        chk("boot_booted_run", 32'(booted), 32'd1);
        chk("boot_first_fgnt", 32'(fetch_gnt), 32'd1);
      end
      if (c == 7) begin
        chk("boot_valid", 32'(fetch_valid), 32'd1);
        chk("boot_instr", fetch_instr, 32'h1000_0000);
      end
      next_cycle();
    end
    load_req  = 1'b0;
    load_done = 1'b0;

    // Starvation bound: one idle cycle to clear history, then continuous contention.
    fetch_req = 1'b0;
    settle();
    next_cycle();
    f_pat = 12'b0000_1000_0100;
    for (int c = 0; c < 12; c++) begin
      fetch_req  = 1'b1;
      fetch_addr = 32'h8;
      load_req   = 1'b1;
      load_addr  = AW'(100);
      load_data  = 32'hA5A5_0000;
      settle();
      chk("starve_fgnt", 32'(fetch_gnt), 32'(f_pat[c]));
      chk("starve_lgnt", 32'(load_gnt), 32'(!f_pat[c]));
      next_cycle();
    end
    fetch_req = 1'b0;
    load_req  = 1'b0;
    settle();
    next_cycle();

    // Read-after-write.
    load_req  = 1'b1;
    load_addr = AW'(5);
    load_data = 32'hDEAD_BEEF;
    settle();
    chk("raw_lgnt", 32'(load_gnt), 32'd1);
    chk("raw_we", 32'(mem_we), 32'd1);
    next_cycle();
    load_req   = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h14;
    settle();
    chk("raw_fgnt", 32'(fetch_gnt), 32'd1);
    chk("raw_maddr", 32'(mem_addr), 32'd5);
    next_cycle();
    fetch_req = 1'b0;
    settle();
    chk("raw_valid", 32'(fetch_valid), 32'd1);
    chk("raw_instr", fetch_instr, 32'hDEAD_BEEF);
    chk("raw_err", 32'(fetch_err), 32'd0);
    next_cycle();

    // Error fetches.
    fetch_req  = 1'b1;
    fetch_addr = 32'h6;
    settle();
    chk("err1_fgnt", 32'(fetch_gnt), 32'd1);
    chk("err1_we", 32'(mem_we), 32'd0);
    next_cycle();
    fetch_addr = 32'h200;
    settle();
    chk("err2_fgnt", 32'(fetch_gnt), 32'd1);
    chk("err2_we", 32'(mem_we), 32'd0);
    chk("err1_valid", 32'(fetch_valid), 32'd1);
    chk("err1_err", 32'(fetch_err), 32'd1);
    chk("err1_instr", fetch_instr, 32'h0);
    next_cycle();
    fetch_req = 1'b0;
    settle();
    chk("err2_valid", 32'(fetch_valid), 32'd1);
    chk("err2_err", 32'(fetch_err), 32'd1);
    chk("err2_instr", fetch_instr, 32'h0);
    chk("err2_we_after", 32'(mem_we), 32'd0);
    next_cycle();

    // Vector table; the previous cycle had fetch_req=0 so no burst history.
    vecs[0] = '{1'b1, 32'h8,        1'b0, AW'(0),  32'h0,  1'b1, 1'b0, 1'b0, AW'(2),   32'h0};
    vecs[1] = '{1'b0, 32'h0,        1'b1, AW'(9),  32'h55, 1'b0, 1'b1, 1'b1, AW'(9),   32'h55};
    vecs[2] = '{1'b1, 32'h24,       1'b1, AW'(10), 32'h66, 1'b0, 1'b1, 1'b1, AW'(10),  32'h66};
    vecs[3] = '{1'b1, 32'h24,       1'b0, AW'(0),  32'h0,  1'b1, 1'b0, 1'b0, AW'(9),   32'h0};
    vecs[4] = '{1'b1, 32'h1FC,      1'b0, AW'(0),  32'h0,  1'b1, 1'b0, 1'b0, AW'(127), 32'h0};
    vecs[5] = '{1'b0, 32'h0,        1'b0, AW'(0),  32'h0,  1'b0, 1'b0, 1'b0, AW'(0),   32'h0};
    vecs[6] = '{1'b1, 32'h8000_0000, 1'b0, AW'(0), 32'h0,  1'b1, 1'b0, 1'b0, AW'(0),   32'h0};
    vecs[7] = '{1'b1, 32'h4,        1'b1, AW'(11), 32'h77, 1'b0, 1'b1, 1'b1, AW'(11),  32'h77};
    vecs[8] = '{1'b1, 32'h4,        1'b0, AW'(0),  32'h0,  1'b1, 1'b0, 1'b0, AW'(1),   32'h0};
    for (int i = 0; i < 9; i++) begin
      fetch_req  = vecs[i].freq;
      fetch_addr = vecs[i].faddr;
      load_req   = vecs[i].lreq;
      load_addr  = vecs[i].laddr;
      load_data  = vecs[i].ldata;
      settle();
      chk("vec_fgnt", 32'(fetch_gnt), 32'(vecs[i].fgnt));
      chk("vec_lgnt", 32'(load_gnt), 32'(vecs[i].lgnt));
      chk("vec_we", 32'(mem_we), 32'(vecs[i].we));
      chk("vec_maddr", 32'(mem_addr), 32'(vecs[i].maddr));
      if (!vecs[i].fgnt) chk("vec_wdata", mem_wdata, vecs[i].wdata);
      next_cycle();
    end

    // Idle drive.
    fetch_req = 1'b0;
    load_req  = 1'b0;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("idle_maddr", 32'(mem_addr), 32'd0);
      chk("idle_wdata", mem_wdata, 32'h0);
      chk("idle_we", 32'(mem_we), 32'd0);
      if (c == 0) begin
        chk("idle_last_valid", 32'(fetch_valid), 32'd1);
        chk("idle_last_instr", fetch_instr, 32'h1000_0001);
      end else begin
        chk("idle_valid", 32'(fetch_valid), 32'd0);
        chk("idle_instr_hold", fetch_instr, 32'h1000_0001);
      end
      next_cycle();
    end

    // Randomized traffic against the behavioural model.
    for (int i = 0; i < int'(Depth); i++) m_mem[i] = mem[i];
    m_wait = 0;
    m_fg   = 1'b0;
    m_lg   = 1'b0;
    m_pv   = 1'b0;
    m_perr = 1'b0;
    m_last = 32'h1000_0001;
    for (int c = 0; c < 400; c++) begin
      if (!(fetch_req && !m_fg)) begin
        fetch_req  = ($urandom_range(0, 3) != 0);
        fetch_addr = rand_faddr();
      end
      if (!(load_req && !m_lg)) begin
        load_req  = ($urandom_range(0, 2) == 0);
        load_addr = AW'($urandom_range(0, Depth - 1));
        load_data = $urandom;
      end
      load_done = ($urandom_range(0, 15) == 0);
      settle();
      m_fg    = fetch_req && (!load_req || m_wait >= int'(MB));
      m_lg    = load_req && !m_fg;
      m_err   = (fetch_addr[1:0] != 2'b00) || (fetch_addr[31:AW+2] != '0);
      m_maddr = m_lg ? load_addr : (m_fg ? fetch_addr[AW+1:2] : '0);
      chk("rnd_fgnt", 32'(fetch_gnt), 32'(m_fg));
      chk("rnd_lgnt", 32'(load_gnt), 32'(m_lg));
      chk("rnd_we", 32'(mem_we), 32'(m_lg));
      chk("rnd_maddr", 32'(mem_addr), 32'(m_maddr));
      if (m_lg) chk("rnd_wdata", mem_wdata, load_data);
      if (!m_fg && !m_lg) chk("rnd_idle_wdata", mem_wdata, 32'h0);
      chk("rnd_booted", 32'(booted), 32'd1);
      chk("rnd_valid", 32'(fetch_valid), 32'(m_pv));
      if (m_pv) chk("rnd_err", 32'(fetch_err), 32'(m_perr));
      chk("rnd_instr", fetch_instr, m_last);
      // Advance the model to the next cycle.
      m_wait = (m_fg || !fetch_req) ? 0 : m_wait + (m_lg ? 1 : 0);
      m_pv   = m_fg;
      m_perr = m_fg && m_err;
      if (m_fg) m_last = m_err ? 32'h0 : m_mem[fetch_addr[AW+1:2]];
      if (m_lg) m_mem[load_addr] = load_data;
      next_cycle();
    end
    load_done = 1'b0;
    load_req  = 1'b0;

    // Reset in the cycle after a fetch grant.
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    settle();
    chk("mrst_fgnt", 32'(fetch_gnt), 32'd1);
    next_cycle();
    reset     = 1'b1;
    fetch_req = 1'b0;
    settle();
    chk("mrst_valid", 32'(fetch_valid), 32'd0);
    chk("mrst_booted", 32'(booted), 32'd0);
    chk("mrst_instr", fetch_instr, 32'h0);
    next_cycle();
    reset      = 1'b0;
    fetch_req  = 1'b1;
    fetch_addr = 32'h4;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("mrst_blocked", 32'(fetch_gnt), 32'd0);
      chk("mrst_valid_low", 32'(fetch_valid), 32'd0);
      next_cycle();
    end
    load_done = 1'b1;
    settle();
    chk("mrst_done_cycle", 32'(fetch_gnt), 32'd0);
    next_cycle();
    load_done = 1'b0;
    settle();
    chk("mrst_rebooted", 32'(booted), 32'd1);
    chk("mrst_fgnt_after", 32'(fetch_gnt), 32'd1);
    next_cycle();
    fetch_req = 1'b0;
    settle();
    chk("mrst_resp_valid", 32'(fetch_valid), 32'd1);
    chk("mrst_resp_instr", fetch_instr, m_mem[1]);
    next_cycle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
